// File: rtl/mips_mc_sequencer.sv
// Multi-cycle MIPS control sequencer: owns PC, IR, link register and the phase FSM,
// and steps the shared datapath through FETCH/DECODE/EXEC/MEM/WB with handshaked memories.
module mips_mc_sequencer #(
    parameter int unsigned             DATA_W          = 32,
    parameter logic [DATA_W-1:0]       RESET_PC        = '0,
    parameter int unsigned             PC_STEP         = 1,
    parameter int unsigned             CNT_W           = 32,
    parameter int unsigned             HALT_ON_ILLEGAL = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ready,
    input  logic              alu_zero,
    input  logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] pc,
    output logic [31:0]       ir,
    output logic              reg_we,
    output logic [1:0]        reg_dst,
    output logic              mem_to_reg,
    output logic              link_sel,
    output logic [DATA_W-1:0] link_pc,
    output logic [2:0]        state,
    output logic              illegal,
    output logic              retire,
    output logic [CNT_W-1:0]  instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t              r_state;
    logic [DATA_W-1:0]   r_pc;
    logic [31:0]         r_ir;
    logic [DATA_W-1:0]   r_link;
    logic [CNT_W-1:0]    r_instret;

    logic                w_is_r, w_is_jr, w_is_addi, w_is_lw, w_is_sw;
    logic                w_is_beq, w_is_bne, w_is_j, w_is_jal, w_legal, w_ctrl_only;
    logic                w_taken, w_retire;
    logic [DATA_W-1:0]   w_pc_next, w_imm, w_br_target, w_j_target;

    assign w_is_r      = (r_ir[31:26] == OP_RTYPE);
    assign w_is_jr     = w_is_r && (r_ir[5:0] == FN_JR);
    assign w_is_addi   = (r_ir[31:26] == OP_ADDI);
    assign w_is_lw     = (r_ir[31:26] == OP_LW);
    assign w_is_sw     = (r_ir[31:26] == OP_SW);
    assign w_is_beq    = (r_ir[31:26] == OP_BEQ);
    assign w_is_bne    = (r_ir[31:26] == OP_BNE);
    assign w_is_j      = (r_ir[31:26] == OP_J);
    assign w_is_jal    = (r_ir[31:26] == OP_JAL);
    assign w_legal     = w_is_r | w_is_addi | w_is_lw | w_is_sw |
                         w_is_beq | w_is_bne | w_is_j | w_is_jal;
    // Branches and plain jumps finish in EXEC; nothing to write back.
    assign w_ctrl_only = w_is_beq | w_is_bne | w_is_j | w_is_jr;

    // r_pc already points past the instruction once we leave FETCH.
    assign w_pc_next   = r_pc + DATA_W'(PC_STEP);
    assign w_imm       = {{(DATA_W-16){r_ir[15]}}, r_ir[15:0]};
    assign w_br_target = r_pc + w_imm;
    assign w_j_target  = {r_pc[DATA_W-1:26], r_ir[25:0]};
    assign w_taken     = (w_is_beq && alu_zero) || (w_is_bne && !alu_zero);

    assign w_retire = ((r_state == S_EXEC) && w_ctrl_only) ||
                      ((r_state == S_MEM) && w_is_sw && dmem_ready) ||
                      (r_state == S_WB);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_link    <= '0;
            r_instret <= '0;
        end else begin
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            case (r_state)
                S_IDLE: r_state <= S_FETCH;
                S_FETCH: begin
                    if (imem_ready) begin
                        r_ir    <= imem_rdata;
                        r_pc    <= w_pc_next;
                        r_link  <= w_pc_next;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!w_legal) begin
                        r_state <= (HALT_ON_ILLEGAL != 0) ? S_HALT : S_FETCH;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_is_beq || w_is_bne) begin
                        if (w_taken) r_pc <= w_br_target;
                        r_state <= S_FETCH;
                    end else if (w_is_j) begin
                        r_pc    <= w_j_target;
                        r_state <= S_FETCH;
                    end else if (w_is_jr) begin
                        r_pc    <= rs_data;
                        r_state <= S_FETCH;
                    end else if (w_is_lw || w_is_sw) begin
                        r_state <= S_MEM;
                    end else begin
                        if (w_is_jal) r_pc <= w_j_target;
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        r_state <= w_is_sw ? S_FETCH : S_WB;
                    end
                end
                S_WB:    r_state <= S_FETCH;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_req   = (r_state == S_FETCH);
    assign imem_addr  = r_pc;
    assign dmem_req   = (r_state == S_MEM);
    assign dmem_we    = (r_state == S_MEM) && w_is_sw;
    assign reg_we     = (r_state == S_WB);
    assign reg_dst    = w_is_jal ? 2'd2 : (w_is_r ? 2'd1 : 2'd0);
    assign mem_to_reg = (r_state == S_WB) && w_is_lw;
    assign link_sel   = (r_state == S_WB) && w_is_jal;
    assign link_pc    = r_link;
    assign pc         = r_pc;
    assign ir         = r_ir;
    assign state      = r_state;
    assign illegal    = (r_state == S_DECODE) && !w_legal;
    assign retire     = w_retire;
    assign instret    = r_instret;

endmodule

// File: tb/tb_mips_mc_sequencer.sv
// Bench for mips_mc_sequencer: directed vector table, reset corner cases and random
// instruction streams checked against an instruction-level phase/PC model.
module tb_mips_mc_sequencer;

    localparam logic [31:0] RPC1 = 32'h5;
    localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3, P_MEM = 4, P_WB = 5, P_HALT = 6;
    localparam int K_R = 0, K_JR = 1, K_ADDI = 2, K_LW = 3, K_SW = 4, K_BEQ = 5, K_BNE = 6,
                   K_J = 7, K_JAL = 8, K_ILL = 9;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        imem_ready, dmem_ready, alu_zero;
    logic [31:0] imem_rdata, rs_data;

    logic        imem_req, dmem_req, dmem_we, reg_we, mem_to_reg, link_sel, illegal, retire;
    logic [31:0] imem_addr, pc, ir, link_pc, instret;
    logic [1:0]  reg_dst;
    logic [2:0]  state;

    logic        imem_req1, dmem_req1, dmem_we1, reg_we1, mem_to_reg1, link_sel1, illegal1, retire1;
    logic [31:0] imem_addr1, pc1, ir1, link_pc1;
    logic [3:0]  instret1;
    logic [1:0]  reg_dst1;
    logic [2:0]  state1;

    always #5 clock = ~clock;

    mips_mc_sequencer dut0 (
        .clock(clock), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .alu_zero(alu_zero), .rs_data(rs_data), .pc(pc), .ir(ir),
        .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .link_sel(link_sel),
        .link_pc(link_pc), .state(state), .illegal(illegal), .retire(retire), .instret(instret)
    );

    mips_mc_sequencer #(.RESET_PC(RPC1), .CNT_W(4), .HALT_ON_ILLEGAL(1)) dut1 (
        .clock(clock), .reset_n(reset_n),
        .imem_req(imem_req1), .imem_addr(imem_addr1), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req1), .dmem_we(dmem_we1), .dmem_ready(dmem_ready),
        .alu_zero(alu_zero), .rs_data(rs_data), .pc(pc1), .ir(ir1),
        .reg_we(reg_we1), .reg_dst(reg_dst1), .mem_to_reg(mem_to_reg1), .link_sel(link_sel1),
        .link_pc(link_pc1), .state(state1), .illegal(illegal1), .retire(retire1), .instret(instret1)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mpc;
    int unsigned minstret;
    bit          lock1, halt1;

    typedef struct {
        logic [31:0] ins;
        int          iw;
        int          dw;
        bit          zero;
        logic [31:0] rs;
        int          cyc;
        logic [31:0] npc;
        int          ret;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int kind_of(input logic [31:0] ins);
        case (ins[31:26])
            6'd0:    return (ins[5:0] == 6'd8) ? K_JR : K_R;
            6'd8:    return K_ADDI;
            6'd35:   return K_LW;
            6'd43:   return K_SW;
            6'd4:    return K_BEQ;
            6'd5:    return K_BNE;
            6'd2:    return K_J;
            6'd3:    return K_JAL;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] ins, input logic [31:0] pc0,
                                            input bit zero, input logic [31:0] rs);
        logic [31:0] p1, off, tgt;
        p1  = pc0 + 32'd1;
        off = {{16{ins[15]}}, ins[15:0]};
        tgt = {p1[31:26], ins[25:0]};
        case (kind_of(ins))
            K_BEQ:   return zero ? p1 + off : p1;
            K_BNE:   return zero ? p1 : p1 + off;
            K_J:     return tgt;
            K_JAL:   return tgt;
            K_JR:    return rs;
            default: return p1;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: begin r[31:26] = 6'd0; if (r[5:0] == 6'd8) r[5:0] = 6'd32; end
            1: begin r[31:26] = 6'd0; r[5:0] = 6'd8; end
            2: r[31:26] = 6'd8;
            3: r[31:26] = 6'd35;
            4: r[31:26] = 6'd43;
            5: r[31:26] = 6'd4;
            6: r[31:26] = 6'd5;
            7: r[31:26] = 6'd2;
            8: r[31:26] = 6'd3;
            default: if (kind_of(r) != K_ILL) r[31:26] = 6'h3F;
        endcase
        return r;
    endfunction

    // Entered one time unit after the edge that starts the instruction's first FETCH
    // cycle; returns one time unit after the edge that starts the following cycle.
    task automatic run_instr(input logic [31:0] ins, input int iw, input int dw,
                             input bit zero, input logic [31:0] rs, output int ncyc);
        int k;
        int ph[$];
        logic [31:0] npc;
        k = kind_of(ins);
        for (int i = 0; i <= iw; i++) ph.push_back(P_FETCH);
        ph.push_back(P_DECODE);
        if (k != K_ILL) begin
            ph.push_back(P_EXEC);
            if (k == K_LW || k == K_SW) for (int i = 0; i <= dw; i++) ph.push_back(P_MEM);
            if (k == K_R || k == K_ADDI || k == K_LW || k == K_JAL) ph.push_back(P_WB);
        end
        npc = next_pc(ins, mpc, zero, rs);
        for (int c = 0; c < ph.size(); c++) begin
            int p;
            bit last, mlast;
            p     = ph[c];
            last  = (c == ph.size() - 1);
            mlast = (p == P_MEM) && (last || ph[c+1] != P_MEM);
            if (c > 0) @(posedge clock);
            #2;
            imem_rdata = $urandom;
            imem_ready = (p == P_FETCH) ? 1'b0 : 1'($urandom_range(0, 1));
            if (p == P_FETCH && c == iw) begin
                imem_ready = 1'b1;
                imem_rdata = ins;
            end
            dmem_ready = (p == P_MEM) ? mlast : 1'($urandom_range(0, 1));
            alu_zero   = (p == P_EXEC) ? zero : 1'($urandom_range(0, 1));
            rs_data    = (p == P_EXEC) ? rs : $urandom;
            #2;
            chk("state", state, p);
            chk("imem_req", imem_req, p == P_FETCH);
            if (p == P_FETCH) begin
                chk("imem_addr", imem_addr, mpc);
                chk("pc_fetch", pc, mpc);
            end
            if (p == P_DECODE) chk("pc_decode", pc, mpc + 32'd1);
            if (p != P_FETCH) chk("ir", ir, ins);
            chk("dmem_req", dmem_req, p == P_MEM);
            chk("dmem_we", dmem_we, p == P_MEM && k == K_SW);
            chk("reg_we", reg_we, p == P_WB);
            if (p == P_WB) begin
                chk("reg_dst", reg_dst, (k == K_JAL) ? 2 : ((k == K_R) ? 1 : 0));
                chk("mem_to_reg", mem_to_reg, k == K_LW);
                chk("link_sel", link_sel, k == K_JAL);
                if (k == K_JAL) chk("link_pc", link_pc, mpc + 32'd1);
            end
            chk("retire", retire, last && k != K_ILL);
            chk("illegal", illegal, p == P_DECODE && k == K_ILL);
            if (c == 0) chk("instret", instret, minstret);
            if (lock1) begin
                chk("state1", state1, p);
                chk("retire1", retire1, last && k != K_ILL);
                chk("illegal1", illegal1, p == P_DECODE && k == K_ILL);
                if (c == 0) chk("instret1", instret1, minstret % 16);
            end else if (halt1) begin
                chk("halt_state1", state1, P_HALT);
                chk("halt_strobes1", {imem_req1, dmem_req1, dmem_we1, reg_we1, mem_to_reg1,
                                      link_sel1, retire1, illegal1}, 0);
            end
        end
        mpc = npc;
        if (k != K_ILL) minstret++;
        if (k == K_ILL && lock1) begin
            lock1 = 1'b0;
            halt1 = 1'b1;
        end
        ncyc = ph.size();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        mpc      = 32'd0;
        minstret = 0;
        lock1    = 1'b1;
        halt1    = 1'b0;
    endtask

    initial begin
        vec_t tbl[$];
        int   n;
        logic [31:0] ins;

        tbl.push_back('{32'h20010005, 0, 0, 1'b0, 32'h0,  4, 32'h001,  1}); // addi
        tbl.push_back('{32'h8C220004, 0, 3, 1'b0, 32'h0,  8, 32'h002,  2}); // lw, 3 wait
        tbl.push_back('{32'hAC220008, 1, 0, 1'b0, 32'h0,  5, 32'h003,  3}); // sw, imem wait
        tbl.push_back('{32'h0800000A, 0, 0, 1'b0, 32'h0,  3, 32'h00A,  4}); // j 10
        tbl.push_back('{32'h1000FFFD, 0, 0, 1'b1, 32'h0,  3, 32'h008,  5}); // beq taken
        tbl.push_back('{32'h0800000A, 0, 0, 1'b0, 32'h0,  3, 32'h00A,  6});
        tbl.push_back('{32'h1000FFFD, 0, 0, 1'b0, 32'h0,  3, 32'h00B,  7}); // beq not taken
        tbl.push_back('{32'h0800000A, 0, 0, 1'b0, 32'h0,  3, 32'h00A,  8});
        tbl.push_back('{32'h1400FFFD, 0, 0, 1'b0, 32'h0,  3, 32'h008,  9}); // bne taken
        tbl.push_back('{32'h0800000A, 0, 0, 1'b0, 32'h0,  3, 32'h00A, 10});
        tbl.push_back('{32'h1400FFFD, 0, 0, 1'b1, 32'h0,  3, 32'h00B, 11}); // bne not taken
        tbl.push_back('{32'h08000020, 0, 0, 1'b0, 32'h0,  3, 32'h020, 12});
        tbl.push_back('{32'h0C000100, 0, 0, 1'b0, 32'h0,  4, 32'h100, 13}); // jal
        tbl.push_back('{32'h03E00008, 0, 0, 1'b0, 32'h21, 3, 32'h021, 14}); // jr
        tbl.push_back('{32'h00221820, 2, 0, 1'b0, 32'h0,  6, 32'h022, 15}); // add, 2 wait
        tbl.push_back('{32'h20010001, 0, 0, 1'b0, 32'h0,  4, 32'h023, 16}); // 4-bit count wraps
        tbl.push_back('{32'hFC000000, 0, 0, 1'b0, 32'h0,  2, 32'h024, 16}); // illegal
        tbl.push_back('{32'h20010002, 0, 0, 1'b0, 32'h0,  4, 32'h025, 17});

        reset_n    = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'h20010005;
        dmem_ready = 1'b1;
        alu_zero   = 1'b0;
        rs_data    = 32'h0;
        model_reset();
        #23;
        chk("rst_state", state, P_IDLE);
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_instret", instret, 32'h0);
        chk("rst_link", link_pc, 32'h0);
        chk("rst_strobes", {imem_req, dmem_req, dmem_we, reg_we, mem_to_reg, link_sel, retire, illegal}, 0);
        chk("rst_pc1", pc1, RPC1);
        chk("rst_addr1", imem_addr1, RPC1);
        chk("rst_ir1", ir1, 32'h0);
        chk("rst_link1", link_pc1, 32'h0);
        chk("rst_instret1", instret1, 32'h0);

        @(posedge clock);
        #2 reset_n = 1'b1;
        #2;
        chk("idle_after_rst", state, P_IDLE);
        chk("idle_req", imem_req, 1'b0);
        chk("idle_after_rst1", state1, P_IDLE);
        @(posedge clock);
        #1;

        foreach (tbl[i]) begin
            run_instr(tbl[i].ins, tbl[i].iw, tbl[i].dw, tbl[i].zero, tbl[i].rs, n);
            chk("tbl_cycles", n, tbl[i].cyc);
            chk("tbl_pc", pc, tbl[i].npc);
            chk("tbl_instret", instret, tbl[i].ret);
        end
        chk("halted1_state", state1, P_HALT);
        chk("halted1_req", imem_req1, 1'b0);

        // Reset asserted while a fetch is waiting for imem_ready.
        #2 imem_ready = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_req", imem_req, 1'b0);
        chk("midrst_state", state, P_IDLE);
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_instret", instret, 32'h0);
        chk("midrst_pc1", pc1, RPC1);
        @(posedge clock);
        #2;
        imem_ready = 1'b1;
        imem_rdata = 32'h20010007;
        reset_n    = 1'b1;
        #2;
        chk("midrst_idle", state, P_IDLE);
        @(posedge clock);
        #1;
        chk("late_ready_state", state, P_FETCH);
        chk("late_ready_ir", ir, 32'h0);
        chk("late_ready_pc", pc, 32'h0);
        model_reset();

        for (int i = 0; i < 250; i++) begin
            ins = rand_instr();
            run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      $urandom, n);
            chk("rnd_pc", pc, mpc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
